fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Drains the single-clock FIFO and presents its contents as a valid/ready stream to downstream logic. Issues FIFO read strobes, absorbs the FIFO's one-cycle read latency, and holds the words in a small registered output buffer. Sustains one word per cycle with no combinational path from `out_ready` to the FIFO read strobe. Sits directly downstream of the FIFO in the same clock domain.

## Interface
- `N`, default 4: data width in bits; must match the FIFO data width.
- `B`, default 3: output buffer depth in words; minimum 3 for full throughput.
- `C`, default 8: width of the delivered-word counter.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset; clock `clk`.
- `en`  in  1: read enable; when low, no new FIFO reads are issued; the buffer still drains.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_data`  in  signed [N-1:0]: FIFO read data; valid the cycle after a read strobe.
- `fifo_r_en`  out  1: FIFO read strobe.
- `out_valid`  out  1: `out_data` holds a word.
- `out_ready`  in  1: downstream accepts the word.
- `out_data`  out  signed [N-1:0]: head word of the buffer.
- `occupancy`  out  [$clog2(B+1)-1:0]: words currently in the buffer.
- `word_count`  out  [C-1:0]: words delivered since reset; wraps modulo 2^C.

## Operation
- **Pending bit `pend`:** set to 1 on every cycle in which `fifo_r_en` is high; otherwise 0. Exactly one cycle of read latency.
- **Read strobe:** `fifo_r_en = en & !fifo_empty & (occupancy + pend < B)`.
  - Depends on registered state only, plus `en` and `fifo_empty`.
  - The strobe never overruns the buffer, even if `out_ready` stays low.
- **Capture:** when `pend` is 1, `fifo_data` is written at the buffer tail on that clock edge.
- **Output:** `out_valid = (occupancy != 0)`; `out_data` is the buffer head. When head is empty, `out_data` holds its last value (0 after reset).
- **Transfer (fire):** `out_valid & out_ready`. On fire, the head pops and `word_count` increments.
- **Same-cycle capture and fire:** `occupancy` is unchanged; word order is preserved.
- **Circular buffer:** head/tail pointers wrap modulo B. `occupancy` updates as +capture −fire.
- **`en` falling:** an in-flight read (`pend` = 1) is still captured and no further reads are issued.
- **`out_ready` high while `out_valid` low:** ignored.
- **Word order:** strictly FIFO order; no word is dropped or duplicated.

## Timing
- **Reset values:** `fifo_r_en` 0, `out_valid` 0, `out_data` 0, `occupancy` 0, `word_count` 0, `pend` 0.
- **Reset mid-operation:** all state clears immediately (asynchronous). An in-flight word is discarded; the FIFO resets on the same `rst`.
- **Latency:** a strobe in cycle t puts data in the buffer at the edge ending t+1.
  - `out_valid` rises in cycle t+2 if the buffer was empty.
  - First word out: 2 cycles after the FIFO goes non-empty, with `en` and `out_ready` high.
- **Throughput:** 1 word/cycle steady state with `en`, `!fifo_empty` and `out_ready` all high (B ≥ 3).
- **Backpressure:** with `out_ready` low, at most B words are held and strobes stop. Strobes resume the cycle after the first fire, once `occupancy + pend < B`.

## Structure
- **Shared package `fifo_pkg`:** data typedef `fifo_word_t` (signed [N-1:0]), and a `clog2`-based width constant for `occupancy`.
- **Sub-module `stream_ring_buf`:** B-entry register array with head/tail pointers and occupancy.
  - Ports: `wr`, `wdata`, `rd`, `rdata`, `occupancy`.
  - The top level holds `pend`, the strobe logic and `word_count`.

## Test plan
- **Reset:** assert `rst` mid-stream with 2 words buffered and `pend` = 1 → all outputs 0 the same cycle; after release, the next FIFO word is the first delivered.
- **Streaming:** FIFO holds 3, −2, 7, −8 (N=4); `en` = `out_ready` = 1 → `fifo_r_en` high 4 consecutive cycles; `out_data` 3, −2, 7, −8 on 4 consecutive cycles starting 2 cycles after the first strobe; `word_count` = 4.
- **Backpressure:** `out_ready` = 0, FIFO holds 6 words → exactly 3 strobes, `occupancy` = 3, `fifo_r_en` 0 thereafter. Raise `out_ready` → all 6 words delivered in order, no gaps after the first.
- **Simultaneous capture and fire:** with `occupancy` = 1 and `pend` = 1, fire → `occupancy` stays 1 and the next `out_data` is the captured word.
- **`en` toggle:** drop `en` the cycle after a strobe → that word is still delivered, no further strobes; re-assert → reading resumes with no loss.
- **Wrap-around:** C=3, stream 10 words → `word_count` reads 2; buffer pointers wrap repeatedly with ordering intact.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO stream reader.
// Default word and buffer sizes match the FIFO this block sits behind.
package fifo_pkg;

    localparam int WORD_W = 4;
    localparam int BUF_D  = 3;

    typedef logic signed [WORD_W-1:0] fifo_word_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int OCC_W = occ_w(BUF_D);

endpackage

// File: rtl/stream_ring_buf.sv
// Circular B-entry word buffer with head/tail pointers and occupancy.
// The head word stays visible after the last pop so the output never glitches.
module stream_ring_buf
    import fifo_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic signed [N-1:0]        wdata,
    input  logic                       rd,
    output logic signed [N-1:0]        rdata,
    output logic [$clog2(B+1)-1:0]     occupancy
);

    localparam int AW = (B > 1) ? $clog2(B) : 1;
    localparam int OW = occ_w(B);

    logic signed [N-1:0] mem [B];
    logic signed [N-1:0] last;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [OW-1:0]       count;
    logic                pop;

    function automatic logic [AW-1:0] step(input logic [AW-1:0] p);
        return (p == AW'(B - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop       = rd && (count != '0);
    assign rdata     = (count != '0) ? mem[head] : last;
    assign occupancy = count;

    // Storage array: write at the tail on every capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < B; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers, occupancy and the last popped word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            last  <= '0;
        end else begin
            if (wr) tail <= step(tail);
            if (pop) begin
                head <= step(head);
                last <= mem[head];
            end
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a single-clock FIFO into a registered valid/ready output stream.
// The read strobe looks only at registered state, never at out_ready.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 3,
    parameter int C = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       fifo_empty,
    input  logic signed [N-1:0]        fifo_data,
    output logic                       fifo_r_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [N-1:0]        out_data,
    output logic [$clog2(B+1)-1:0]     occupancy,
    output logic [C-1:0]               word_count
);

    localparam int OW = occ_w(B);

    logic          pend;
    logic          fire;
    logic [OW:0]   inflight;

    // Strobe only while buffered plus in-flight words leave room
    always_comb begin
        inflight  = {1'b0, occupancy} + {{OW{1'b0}}, pend};
        fifo_r_en = en & ~fifo_empty & (inflight < (OW + 1)'(B));
        out_valid = (occupancy != '0);
        fire      = out_valid & out_ready;
    end

    // Track the one-cycle FIFO read latency and count delivered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            word_count <= '0;
        end else begin
            pend <= fifo_r_en;
            if (fire) word_count <= word_count + 1'b1;
        end
    end

    stream_ring_buf #(
        .N (N),
        .B (B)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr        (pend),
        .wdata     (fifo_data),
        .rd        (fire),
        .rdata     (out_data),
        .occupancy (occupancy)
    );

endmodule
